// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and framing constants
package uart_pkg;

    // Receiver/transmitter frame states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

    // Ticks per bit; fixed, the bit timing of the whole link depends on it
    localparam int OVERSAMPLE = 16;
    // Payload bits per 8N1 frame
    localparam int DATA_BITS  = 8;
    // Tick on which the start bit is re-checked (centre of the start bit)
    localparam int MID_TICK   = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator with synchronous clear
module uart_baud_tick #(
    parameter int TICK_DIV = 81
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    // Count 0..TICK_DIV-1; the tick is registered so it lands one cycle after the wrap count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == CW'(TICK_DIV - 1)) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + CW'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver with 16x oversampling and one-entry holding register
module uart_rx
    import uart_pkg::*;
#(
    parameter int TICK_DIV = 81
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uartRxPin,
    input  logic       readAck,
    output logic [7:0] rxData,
    output logic       dataAvailable,
    output logic       framingError,
    output logic       overrun,
    output logic       rxBusy
);

    logic        sync_meta;
    logic        rxSync;
    uart_state_t state;
    logic        tick;
    logic        tick_clear;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;

    // Two-flop synchronizer; idle-high so reset does not look like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            rxSync    <= 1'b1;
        end else begin
            sync_meta <= uartRxPin;
            rxSync    <= sync_meta;
        end
    end

    // Tick phase restarts from the cycle the frame begins
    assign tick_clear = (state == ST_IDLE) || (state == ST_WAIT_HIGH);

    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Frame FSM, shift register and holding register with sticky status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            rxData        <= '0;
            dataAvailable <= 1'b0;
            framingError  <= 1'b0;
            overrun       <= 1'b0;
            rxBusy        <= 1'b0;
        end else begin
            // Consumer acknowledge clears status; a same-cycle load below takes priority
            if (readAck) begin
                dataAvailable <= 1'b0;
                overrun       <= 1'b0;
                framingError  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    bit_idx  <= '0;
                    if (!rxSync) begin
                        state  <= ST_START;
                        rxBusy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (tick_cnt == 4'(MID_TICK - 1)) begin
                            tick_cnt <= '0;
                            if (!rxSync) begin
                                state   <= ST_DATA;
                                bit_idx <= '0;
                            end else begin
                                // Line went back high before mid-bit: a glitch, not a frame
                                state  <= ST_IDLE;
                                rxBusy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rxSync, shift_reg[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == 3'(DATA_BITS - 1)) begin
                                state <= ST_STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
                            tick_cnt <= '0;
                            if (rxSync) begin
                                rxData        <= shift_reg;
                                dataAvailable <= 1'b1;
                                if (dataAvailable && !readAck) begin
                                    overrun <= 1'b1;
                                end
                                // Returning mid-stop-bit lets a slightly fast sender's next start through
                                state  <= ST_IDLE;
                                rxBusy <= 1'b0;
                            end else begin
                                framingError <= 1'b1;
                                state        <= ST_WAIT_HIGH;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end

                ST_WAIT_HIGH: begin
                    // A held-low break must not be mistaken for a new start bit
                    if (rxSync) begin
                        state  <= ST_IDLE;
                        rxBusy <= 1'b0;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    rxBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int TICK_DIV = 4;
    localparam int BIT      = 16 * TICK_DIV;

    logic       clk;
    logic       reset;
    logic       uartRxPin;
    logic       readAck;
    logic [7:0] rxData;
    logic       dataAvailable;
    logic       framingError;
    logic       overrun;
    logic       rxBusy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int drop_cyc = 0;
    int da_rise_cyc = 0;
    logic da_q = 1'b0;

    uart_rx #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uartRxPin     (uartRxPin),
        .readAck       (readAck),
        .rxData        (rxData),
        .dataAvailable (dataAvailable),
        .framingError  (framingError),
        .overrun       (overrun),
        .rxBusy        (rxBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dataAvailable && !da_q) da_rise_cyc = cyc;
        da_q = dataAvailable;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int stop_len);
        @(posedge clk); #1;
        uartRxPin = 1'b0;
        drop_cyc  = cyc;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 uartRxPin = data[i];
            repeat (BIT) @(posedge clk);
        end
        #1 uartRxPin = stop_bit;
        repeat (stop_len) @(posedge clk);
        #1 uartRxPin = 1'b1;
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 readAck = 1'b1;
        @(posedge clk); #1 readAck = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        uartRxPin = 1'b1;
        readAck   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", rxData, 8'h00);
        check_eq("rst_da", dataAvailable, 1'b0);
        check_eq("rst_fe", framingError, 1'b0);
        check_eq("rst_ov", overrun, 1'b0);
        check_eq("rst_busy", rxBusy, 1'b0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Clean frame with latency measurement: pin drop to dataAvailable = 3 + 609 cycles
        send_frame(8'hA5, 1'b1, BIT);
        check_eq("a5_data", rxData, 8'hA5);
        check_eq("a5_da", dataAvailable, 1'b1);
        check_eq("a5_fe", framingError, 1'b0);
        check_eq("a5_ov", overrun, 1'b0);
        check_eq("a5_latency", da_rise_cyc - drop_cyc, 612);
        check_eq("a5_busy", rxBusy, 1'b0);
        pulse_ack();
        check_eq("a5_ack_da", dataAvailable, 1'b0);

        // Short low glitch is rejected at the start check
        @(posedge clk); #1 uartRxPin = 1'b0;
        repeat (10) @(posedge clk); #1;
        check_eq("glitch_busy", rxBusy, 1'b1);
        repeat (10) @(posedge clk); #1 uartRxPin = 1'b1;
        repeat (30) @(posedge clk); #1;
        check_eq("glitch_idle", rxBusy, 1'b0);
        check_eq("glitch_da", dataAvailable, 1'b0);
        check_eq("glitch_fe", framingError, 1'b0);

        // Framing error with a held-low break, then a good frame
        send_frame(8'h3C, 1'b0, 200);
        check_eq("fe_flag", framingError, 1'b1);
        check_eq("fe_da", dataAvailable, 1'b0);
        check_eq("fe_wait_busy", rxBusy, 1'b1);
        repeat (6) @(posedge clk); #1;
        check_eq("fe_idle", rxBusy, 1'b0);
        send_frame(8'h5A, 1'b1, BIT);
        check_eq("5a_data", rxData, 8'h5A);
        check_eq("5a_da", dataAvailable, 1'b1);
        check_eq("5a_fe_sticky", framingError, 1'b1);
        pulse_ack();
        check_eq("5a_ack_fe", framingError, 1'b0);

        // Back-to-back frames without acknowledge produce overrun
        send_frame(8'h11, 1'b1, BIT);
        send_frame(8'h22, 1'b1, BIT);
        check_eq("ovr_data", rxData, 8'h22);
        check_eq("ovr_da", dataAvailable, 1'b1);
        check_eq("ovr_flag", overrun, 1'b1);
        pulse_ack();
        check_eq("ovr_ack_da", dataAvailable, 1'b0);
        check_eq("ovr_ack_ov", overrun, 1'b0);
        check_eq("ovr_ack_fe", framingError, 1'b0);

        // Acknowledge on the exact load cycle: new byte wins, no overrun
        send_frame(8'h11, 1'b1, BIT);
        check_eq("pend_da", dataAvailable, 1'b1);
        fork
            send_frame(8'h7E, 1'b1, BIT);
            begin
                @(posedge clk);
                repeat (611) @(posedge clk);
                #1 readAck = 1'b1;
                @(posedge clk);
                #1 readAck = 1'b0;
            end
        join
        check_eq("race_data", rxData, 8'h7E);
        check_eq("race_da", dataAvailable, 1'b1);
        check_eq("race_ov", overrun, 1'b0);

        // Asynchronous reset during data bit 4
        fork
            send_frame(8'hFF, 1'b1, BIT);
            begin
                @(posedge clk);
                repeat (340) @(posedge clk);
                #1 reset = 1'b1;
                #1;
                check_eq("mrst_data", rxData, 8'h00);
                check_eq("mrst_da", dataAvailable, 1'b0);
                check_eq("mrst_ov", overrun, 1'b0);
                check_eq("mrst_fe", framingError, 1'b0);
                check_eq("mrst_busy", rxBusy, 1'b0);
                repeat (3) @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        repeat (20) @(posedge clk); #1;
        check_eq("mrst_no_spurious", dataAvailable, 1'b0);
        send_frame(8'h81, 1'b1, BIT);
        check_eq("81_data", rxData, 8'h81);
        check_eq("81_da", dataAvailable, 1'b1);
        check_eq("81_fe", framingError, 1'b0);
        check_eq("81_ov", overrun, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the processor datapath: recovers 8N1 bytes from the board's UART RX pin using 16x oversampling and presents each byte in a one-entry holding register with a data-available flag. It sits directly upstream of the datapath's program/data loader, in the 12.5 MHz DCM clock domain. Framing and overrun conditions are flagged rather than silently dropped, so the loader and LEDs can report link problems.

## Interface
- TICK_DIV, 81, clk cycles per oversample tick; 12.5 MHz / (9600 × 16) ≈ 81
- OVERSAMPLE, 16, ticks per bit; fixed, not to be overridden
- clk  in  1  system clock (DCM 12.5 MHz output)
- reset  in  1  asynchronous, active-high; one clock domain only
- uartRxPin  in  1  raw asynchronous serial input, idle high
- readAck  in  1  one-cycle pulse from consumer: byte taken, clear flags
- rxData  out  8  last received byte (holding register)
- dataAvailable  out  1  holding register contains an unread byte
- framingError  out  1  sticky: a frame ended with stop bit = 0
- overrun  out  1  sticky: a byte was overwritten before readAck
- rxBusy  out  1  high while the FSM is not in IDLE

## Operation
- Reset values: rxData=0x00, dataAvailable=0, framingError=0, overrun=0, rxBusy=0, FSM=IDLE, synchronizer flops=1.
- Input path: 2-flop synchronizer on uartRxPin; all decisions use the second flop (rxSync).
- Tick generator: counter 0..TICK_DIV-1, tick pulse when count==TICK_DIV-1; counter and tick-count cleared whenever FSM leaves IDLE or WAIT_HIGH.
- FSM states:
  - IDLE: rxSync==0 → START.
  - START: on 8th tick sample rxSync; 0 → DATA (bitIdx=0); 1 → IDLE (glitch rejected, no flags).
  - DATA: every 16th tick sample rxSync into shift register, LSB first; after bitIdx==7 sample → STOP.
  - STOP: on 16th tick sample rxSync; 1 → load rxData, set dataAvailable, → IDLE; 0 → set framingError, discard byte, → WAIT_HIGH.
  - WAIT_HIGH: stay until rxSync==1 → IDLE (break condition never retriggers START).
- Overrun: load while dataAvailable==1 and no readAck that cycle → rxData overwritten, overrun=1.
- readAck: clears dataAvailable, overrun, framingError next cycle. Simultaneous readAck and new load → new byte wins: dataAvailable stays 1, overrun not set.
- readAck while dataAvailable==0 is harmless (clears sticky flags only).

## Timing
- Bit period = 16 × TICK_DIV cycles.
- Pin falling edge → rxSync low: 2 cycles; FSM enters START the following cycle (detect cycle D).
- Start check at D + 8·TICK_DIV; data bit n sampled at D + (8 + 16(n+1))·TICK_DIV; stop sampled at D + 152·TICK_DIV.
- dataAvailable / rxData valid one cycle after the stop sample; framingError likewise.
- A new start edge is accepted from the cycle after the FSM returns to IDLE, i.e. mid-stop-bit, which tolerates senders up to ~3% fast.
- Reset asserted mid-frame: all state returns to reset values immediately; partial byte lost, no flags.

## Structure
- Shared package uart_pkg: FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH), OVERSAMPLE=16, DATA_BITS=8, MID_TICK=8; reused by the existing transmitter.
- One sub-module: uart_baud_tick (parameter TICK_DIV; inputs clk, reset, clear; output tick).
- Synchronizer, shift register, bit/tick counters and holding register remain in uart_rx.

## Test plan
- TICK_DIV=4 (bit = 64 cycles) for all sims. Send 0xA5 with valid stop → dataAvailable=1 at D+609 cycles, rxData=0xA5, no flags.
- Low pulse of 20 cycles on idle line → FSM returns to IDLE at start check; dataAvailable, framingError stay 0.
- Send 0x3C with stop bit 0, line held low 200 cycles then high → framingError=1, dataAvailable=0, FSM in WAIT_HIGH until line high; following 0x5A received correctly.
- Send 0x11 then 0x22 back-to-back without readAck → rxData=0x22, dataAvailable=1, overrun=1; readAck → all three cleared next cycle.
- readAck pulse on exactly the load cycle of 0x7E while 0x11 is pending → rxData=0x7E, dataAvailable=1, overrun=0.
- Assert reset during data bit 4 of 0xFF → outputs at reset values, rxBusy=0; next frame 0x81 received cleanly.
